// File: rtl/fxp_to_minifloat_pipe.sv
// Signed fixed-point to {sign, exp, man} minifloat converter with RNE/truncate and sat/underflow counters.
// Latency 3 cycles, 1 sample/cycle; all stages advance together only when the output slot is free or being taken.
// Backpressure: in_ready = !out_valid | out_ready, outputs hold while stalled; `define SUBNORMAL_EN adds subnormal outputs.
module fxp_to_minifloat_pipe #(
  parameter int IN_W   = 18,
  parameter int FRAC_W = 11,
  parameter int EXP_W  = 3,
  parameter int MAN_W  = 4,
  parameter int BIAS   = 3,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_W-1:0]          in_q,
  input  logic                     in_rnd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_fp,
  output logic                     out_sat,
  output logic                     out_uf,
  input  logic                     clr_cnt,
  output logic [CNT_W-1:0]         sat_cnt,
  output logic [CNT_W-1:0]         uf_cnt
);

  localparam int OW = 1 + EXP_W + MAN_W;
  localparam int PW = $clog2(IN_W);
  localparam int EW = $clog2(IN_W + FRAC_W + BIAS + 2) + 2;
  localparam logic signed [EW-1:0] EB_OVF = EW'(2 ** EXP_W);

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // stage 1 state
  logic                 s1_vld, s1_sign, s1_rnd;
  logic [IN_W-1:0]      s1_mag;
  // stage 2 state
  logic                 s2_vld, s2_sign, s2_rnd, s2_zero, s2_grd, s2_stk, s2_sub;
  logic signed [EW-1:0] s2_eb;
  logic [MAN_W-1:0]     s2_man;

  // Unsigned IN_W-bit magnitude keeps the most negative input exact.
  logic [IN_W-1:0] mag_c;
  assign mag_c = in_q[IN_W-1] ? (~in_q + IN_W'(1)) : in_q;

  logic [PW-1:0]        lead_c;
  logic [IN_W-1:0]      norm_c;
  logic signed [EW-1:0] eb_c;
  logic [MAN_W-1:0]     man_c;
  logic                 grd_c, stk_c, sub_c;

  always_comb begin
    lead_c = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (s1_mag[i]) lead_c = PW'(i);
    end
  end

  assign norm_c = s1_mag << (PW'(IN_W - 1) - lead_c);
  assign eb_c   = EW'(lead_c) - EW'(FRAC_W) + EW'(BIAS);

`ifdef SUBNORMAL_EN
  // Subnormal scale is fixed, so the mantissa is a constant shift of the magnitude.
  localparam int SSH = FRAC_W - MAN_W - BIAS + 1;
  localparam logic [IN_W+1:0] SMASK = (IN_W+2)'((1 << (SSH + 1)) - 1);
  logic [IN_W+1:0] sub_w;
  assign sub_w = {s1_mag, 2'b00};
`endif

  always_comb begin
    man_c = norm_c[IN_W-2 -: MAN_W];
    grd_c = norm_c[IN_W-2-MAN_W];
    stk_c = |norm_c[IN_W-3-MAN_W:0];
    sub_c = 1'b0;
`ifdef SUBNORMAL_EN
    if (eb_c[EW-1] || eb_c == '0) begin
      sub_c = 1'b1;
      man_c = MAN_W'(sub_w >> (SSH + 2));
      grd_c = sub_w[SSH+1];
      stk_c = |(sub_w & SMASK);
    end
`endif
  end

  logic                 inc_c, cy_c, sat_c, uf_c;
  logic [MAN_W-1:0]     manr_c;
  logic signed [EW-1:0] ebr_c;
  logic [OW-1:0]        fp_c;

  always_comb begin
    inc_c           = s2_rnd & s2_grd & (s2_stk | s2_man[0]);
    {cy_c, manr_c}  = {1'b0, s2_man} + {{MAN_W{1'b0}}, inc_c};
    ebr_c           = cy_c ? s2_eb + EW'(1) : s2_eb;
    fp_c            = {s2_sign, ebr_c[EXP_W-1:0], manr_c};
    sat_c           = 1'b0;
    uf_c            = 1'b0;
    if (s2_zero) begin
      fp_c = '0;
    end else if (s2_sub) begin
      // A subnormal carrying out of the mantissa lands on the minimum normal.
      if (cy_c)              fp_c = {s2_sign, EXP_W'(1), {MAN_W{1'b0}}};
      else if (manr_c == '0) begin
        fp_c = '0;
        uf_c = 1'b1;
      end else               fp_c = {s2_sign, {EXP_W{1'b0}}, manr_c};
    end else if (ebr_c >= EB_OVF) begin
      fp_c  = {s2_sign, {(OW-1){1'b1}}};
      sat_c = 1'b1;
    end else if (ebr_c[EW-1] || ebr_c == '0) begin
      fp_c = '0;
      uf_c = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld    <= 1'b0;
      s1_sign   <= 1'b0;
      s1_rnd    <= 1'b0;
      s1_mag    <= '0;
      s2_vld    <= 1'b0;
      s2_sign   <= 1'b0;
      s2_rnd    <= 1'b0;
      s2_zero   <= 1'b0;
      s2_grd    <= 1'b0;
      s2_stk    <= 1'b0;
      s2_sub    <= 1'b0;
      s2_eb     <= '0;
      s2_man    <= '0;
      out_valid <= 1'b0;
      out_fp    <= '0;
      out_sat   <= 1'b0;
      out_uf    <= 1'b0;
    end else if (en) begin
      s1_vld    <= in_valid;
      s1_sign   <= in_q[IN_W-1];
      s1_rnd    <= in_rnd;
      s1_mag    <= mag_c;
      s2_vld    <= s1_vld;
      s2_sign   <= s1_sign;
      s2_rnd    <= s1_rnd;
      s2_zero   <= !norm_c[IN_W-1];
      s2_grd    <= grd_c;
      s2_stk    <= stk_c;
      s2_sub    <= sub_c;
      s2_eb     <= eb_c;
      s2_man    <= man_c;
      out_valid <= s2_vld;
      out_fp    <= fp_c;
      out_sat   <= s2_vld & sat_c;
      out_uf    <= s2_vld & uf_c;
    end
  end

  // Counters see only delivered words; clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_cnt <= '0;
      uf_cnt  <= '0;
    end else if (clr_cnt) begin
      sat_cnt <= '0;
      uf_cnt  <= '0;
    end else begin
      if (out_valid && out_ready && out_sat && !(&sat_cnt)) sat_cnt <= sat_cnt + CNT_W'(1);
      if (out_valid && out_ready && out_uf  && !(&uf_cnt))  uf_cnt  <= uf_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fxp_to_minifloat_pipe.sv
// Bench for fxp_to_minifloat_pipe: arithmetic reference model + scoreboard, directed and random traffic.
module tb_fxp_to_minifloat_pipe;

  localparam int CW = 8;

  logic          clk = 1'b0, rst = 1'b1;
  logic          in_valid = 1'b0, in_rnd = 1'b0, out_ready = 1'b1, clr_cnt = 1'b0;
  logic [17:0]   in_q = '0;
  logic          in_ready, out_valid, out_sat, out_uf;
  logic [7:0]    out_fp;
  logic [CW-1:0] sat_cnt, uf_cnt;

  int checks = 0, errors = 0;
  int rmode  = 0;
  bit         d_hl = 1'b0, d_ls = 1'b0, d_lu = 1'b0;
  logic [7:0] d_lfp = '0;

  typedef struct {
    logic [7:0] fp;
    bit sat, uf, hl;
    logic [7:0] lfp;
    bit ls, lu;
  } exp_t;
  exp_t exp_q[$];

  int m_sat = 0, m_uf = 0;
  bit stall = 1'b0;
  logic [9:0] held = '0;

  fxp_to_minifloat_pipe #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_q(in_q), .in_rnd(in_rnd),
    .out_valid(out_valid), .out_ready(out_ready), .out_fp(out_fp), .out_sat(out_sat), .out_uf(out_uf),
    .clr_cnt(clr_cnt), .sat_cnt(sat_cnt), .uf_cnt(uf_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom % 4) != 0;
      default: out_ready = 1'b0;
    endcase
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Round v / 2^sh to an integer, either toward zero or to nearest-even.
  function automatic longint rshift_round(input longint v, input int sh, input bit rne);
    longint q, r, half;
    if (sh <= 0) return v << (-sh);
    q    = v >> sh;
    r    = v - (q << sh);
    half = longint'(1) << (sh - 1);
    if (rne && (r > half || (r == half && q[0]))) q++;
    return q;
  endfunction

  // Reference: value = in_q / 2^11; output = (-1)^s * 1.man * 2^(exp-3), E3M4.
  task automatic model(input logic [17:0] q, input bit rnd,
                       output logic [7:0] fp, output bit sat, output bit uf);
    longint mag, sig;
    int p, e;
    bit s;
    logic [3:0] m4;
    s   = q[17];
    mag = s ? (longint'(1) << 18) - longint'(q) : longint'(q);
    fp  = '0; sat = 1'b0; uf = 1'b0;
    if (mag == 0) return;
    p = 0;
    for (int i = 0; i < 18; i++) if (mag >= (longint'(1) << i)) p = i;
    e = p - 11;
`ifdef SUBNORMAL_EN
    if (e + 3 <= 0) begin
      sig = rshift_round(mag, 5, rnd);   // units of 2^-6
      if (sig == 0)       uf = 1'b1;
      else if (sig >= 16) fp = {s, 3'd1, 4'd0};
      else begin
        m4 = 4'(sig);
        fp = {s, 3'd0, m4};
      end
      return;
    end
`endif
    sig = rshift_round(mag, p - 4, rnd);
    if (sig == 32) begin
      sig = 16;
      e++;
    end
    if (e + 3 >= 8) begin
      fp  = {s, 7'h7F};
      sat = 1'b1;
    end else if (e + 3 <= 0) begin
      uf = 1'b1;
    end else begin
      m4 = 4'(sig - 16);
      fp = {s, 3'(e + 3), m4};
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    bit hs_s, hs_u;
    if (rst) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_fp", out_fp, 0);
      chk("rst_flags", {out_sat, out_uf}, 0);
      chk("rst_sat_cnt", sat_cnt, 0);
      chk("rst_uf_cnt", uf_cnt, 0);
      exp_q.delete();
      m_sat = 0; m_uf = 0; stall = 1'b0;
    end else begin
      chk("in_ready", in_ready, !out_valid || out_ready);
      chk("sat_cnt", sat_cnt, m_sat);
      chk("uf_cnt", uf_cnt, m_uf);
      if (stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_hold", {out_fp, out_sat, out_uf}, held);
      end
      hs_s = 1'b0; hs_u = 1'b0;
      if (out_valid && out_ready) begin
        chk("out_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("out_fp", out_fp, e.fp);
          chk("out_sat", out_sat, e.sat);
          chk("out_uf", out_uf, e.uf);
          if (e.hl) begin
            chk("lit_fp", out_fp, e.lfp);
            chk("lit_flags", {out_sat, out_uf}, {e.ls, e.lu});
          end
          hs_s = e.sat; hs_u = e.uf;
        end
      end
      stall = out_valid && !out_ready;
      held  = {out_fp, out_sat, out_uf};
      if (in_valid && in_ready) begin
        model(in_q, in_rnd, e.fp, e.sat, e.uf);
        e.hl = d_hl; e.lfp = d_lfp; e.ls = d_ls; e.lu = d_lu;
        exp_q.push_back(e);
      end
      if (clr_cnt) begin
        m_sat = 0; m_uf = 0;
      end else begin
        if (hs_s && m_sat != (1 << CW) - 1) m_sat++;
        if (hs_u && m_uf  != (1 << CW) - 1) m_uf++;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [17:0] q, input bit rnd, input bit hl,
                      input logic [7:0] lfp, input bit ls, input bit lu);
    bit ok;
    int t;
    in_valid = 1'b1; in_q = q; in_rnd = rnd;
    d_hl = hl; d_lfp = lfp; d_ls = ls; d_lu = lu;
    ok = 1'b0; t = 0;
    while (!ok && t < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    chk("send_accepted", ok, 1);
    in_valid = 1'b0; d_hl = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] rand_q();
    logic [31:0] v;
    logic [17:0] r;
    v = $urandom;
    case (v[31:30])
      2'd0:    r = v[17:0];
      2'd1:    r = {8'd0, v[9:0]};
      2'd2:    r = 18'h0F000 + {7'd0, v[10:0]};
      default: r = {6'd0, v[11:0]};
    endcase
    if (v[29]) r = -r;
    return r;
  endfunction

  logic [17:0] tq [12] = '{18'h00800, 18'h01400, 18'h3F800, 18'h008C0, 18'h008C0, 18'h00FC0,
                           18'h0F800, 18'h14000, 18'h20000, 18'h0FC00, 18'h000CD, 18'h00000};
  bit          tr [12] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1};
  bit          ts [12] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0};
`ifdef SUBNORMAL_EN
  logic [7:0]  tf [12] = '{8'h30, 8'h44, 8'hB0, 8'h32, 8'h31, 8'h40, 8'h7F, 8'h7F, 8'hFF, 8'h7F, 8'h06, 8'h00};
  bit          tu [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`else
  logic [7:0]  tf [12] = '{8'h30, 8'h44, 8'hB0, 8'h32, 8'h31, 8'h40, 8'h7F, 8'h7F, 8'hFF, 8'h7F, 8'h00, 8'h00};
  bit          tu [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
`endif

  initial begin : watchdog
    #1000000;
    errors++;
    $display("FAIL watchdog simulation did not complete, expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : main
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // Latency from an empty pipe: visible in the third cycle after acceptance.
    send(18'h00800, 1'b1, 1'b1, 8'h30, 1'b0, 1'b0);
    @(negedge clk); chk("lat_c1_valid", out_valid, 0);
    @(negedge clk); chk("lat_c2_valid", out_valid, 0);
    @(negedge clk); chk("lat_c3_valid", out_valid, 1);
    chk("lat_c3_fp", out_fp, 8'h30);
    drain();

    for (int i = 0; i < 12; i++) send(tq[i], tr[i], 1'b1, tf[i], ts[i], tu[i]);
    drain();

    // Five-cycle output stall in the middle of an eight-sample burst.
    fork
      begin
        for (int i = 0; i < 8; i++) send(rand_q(), 1'($urandom % 2), 1'b0, 8'h00, 1'b0, 1'b0);
      end
      begin
        idle(3);
        rmode = 2;
        idle(2);
        @(negedge clk);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        idle(3);
        rmode = 0;
      end
    join
    drain();

    rmode = 1;
    for (int i = 0; i < 400; i++) begin
      send(rand_q(), 1'($urandom % 2), 1'b0, 8'h00, 1'b0, 1'b0);
      if ($urandom % 4 == 0) idle(int'($urandom % 3) + 1);
    end
    rmode = 0;
    drain();

    for (int i = 0; i < (1 << CW) + 3; i++) send(18'h14000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    drain();
    @(negedge clk);
    chk("sat_cnt_saturated", sat_cnt, 8'hFF);
    @(posedge clk); #1;

    clr_cnt = 1'b1;
    for (int i = 0; i < 3; i++) send(18'h14000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    drain();
    clr_cnt = 1'b0;
    @(negedge clk);
    chk("clr_sat_cnt", sat_cnt, 0);
    chk("clr_uf_cnt", uf_cnt, 0);
    @(posedge clk); #1;

    send(18'h000CD, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    send(18'h20000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    drain();

    // Reset with three samples in flight.
    for (int i = 0; i < 3; i++) send(18'h14000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    idle(2);
    rst = 1'b0;
    idle(8);
    @(negedge clk);
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_sat_cnt", sat_cnt, 0);
    @(posedge clk); #1;
    send(18'h01400, 1'b1, 1'b1, 8'h44, 1'b0, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
